nerv_mem_arbiter: RTL and testbench

Single-port memory arbiter between the NERV core and one unified instruction/data memory. Each core issue cycle, it captures the fetch address and any data request. It serialises them onto one valid/ready memory port (data access first, then fetch) and holds the core with `cpu_stall` until both are done. Results are returned in held registers that stay stable while the core is stalled.

---
 rtl/nerv_pkg.sv | 13 +
 rtl/nerv_mem_arbiter.sv | 102 ++++++++++
 tb/tb_nerv_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nerv_pkg.sv
// Shared types and constants for the NERV memory-side logic.
package nerv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    DACC  = 2'd1,
    IACC  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/nerv_mem_arbiter.sv
// Serialises the NERV core's data access and instruction fetch onto one
// valid/ready memory port, stalling the core until both complete.
module nerv_mem_arbiter
  import nerv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] cpu_imem_addr,
  output logic [XLEN-1:0]   cpu_imem_data,
  input  logic              cpu_dmem_valid,
  input  logic [ADDR_W-1:0] cpu_dmem_addr,
  input  logic [STRB_W-1:0] cpu_dmem_wstrb,
  input  logic [XLEN-1:0]   cpu_dmem_wdata,
  output logic [XLEN-1:0]   cpu_dmem_rdata,
  output logic              cpu_stall,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ia_q;
  logic [ADDR_W-1:0] da_q;
  logic [STRB_W-1:0] dw_q;
  logic [XLEN-1:0]   dd_q;
  logic [XLEN-1:0]   imem_data_q;
  logic [XLEN-1:0]   dmem_rdata_q;

  assign cpu_imem_data  = imem_data_q;
  assign cpu_dmem_rdata = dmem_rdata_q;

  // State register plus request capture and result holding registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ISSUE;
      ia_q         <= '0;
      da_q         <= '0;
      dw_q         <= '0;
      dd_q         <= '0;
      imem_data_q  <= '0;
      dmem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ISSUE: begin
          ia_q <= cpu_imem_addr;
          if (cpu_dmem_valid) begin
            da_q <= cpu_dmem_addr;
            dw_q <= cpu_dmem_wstrb;
            dd_q <= cpu_dmem_wdata;
          end
        end
        DACC: begin
          // Stores keep the previous load result visible to the core.
          if (mem_ready && (dw_q == '0)) dmem_rdata_q <= mem_rdata;
        end
        IACC: begin
          if (mem_ready) imem_data_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Next state and memory-port decode; memory side reads zero when idle.
  always_comb begin
    state_d   = state_q;
    cpu_stall = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    case (state_q)
      ISSUE: begin
        state_d = cpu_dmem_valid ? DACC : IACC;
      end
      DACC: begin
        cpu_stall = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = da_q;
        mem_wstrb = dw_q;
        mem_wdata = dd_q;
        if (mem_ready) state_d = IACC;
      end
      IACC: begin
        cpu_stall = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = ia_q;
        if (mem_ready) state_d = ISSUE;
      end
      default: begin
        state_d = ISSUE;
      end
    endcase
  end

endmodule

// File: tb/tb_nerv_mem_arbiter.sv
// Directed and randomised checks of nerv_mem_arbiter against a bench-side
// memory and reference model.
module tb_nerv_mem_arbiter;

  logic        clock;
  logic        resetn;
  logic [31:0] cpu_imem_addr;
  logic [31:0] cpu_imem_data;
  logic        cpu_dmem_valid;
  logic [31:0] cpu_dmem_addr;
  logic [3:0]  cpu_dmem_wstrb;
  logic [31:0] cpu_dmem_wdata;
  logic [31:0] cpu_dmem_rdata;
  logic        cpu_stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  assign mem_rdata = mem[mem_addr[9:2]];

  nerv_mem_arbiter #(.ADDR_W(32)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .cpu_imem_addr  (cpu_imem_addr),
    .cpu_imem_data  (cpu_imem_data),
    .cpu_dmem_valid (cpu_dmem_valid),
    .cpu_dmem_addr  (cpu_dmem_addr),
    .cpu_dmem_wstrb (cpu_dmem_wstrb),
    .cpu_dmem_wdata (cpu_dmem_wdata),
    .cpu_dmem_rdata (cpu_dmem_rdata),
    .cpu_stall      (cpu_stall),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_wstrb      (mem_wstrb),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] strb,
                                        input logic [31:0] data);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
    return w;
  endfunction

  // Advance one cycle from a negedge to the next; accepted stores land in memory.
  task automatic tick();
    logic        wr;
    logic [31:0] a, d;
    logic [3:0]  s;
    wr = mem_valid && mem_ready && (mem_wstrb != 4'b0);
    a = mem_addr; s = mem_wstrb; d = mem_wdata;
    @(posedge clock);
    @(negedge clock);
    if (wr) mem[a[9:2]] = merge(mem[a[9:2]], s, d);
  endtask

  task automatic garbage();
    cpu_imem_addr  = $urandom;
    cpu_dmem_valid = 1'($urandom_range(0, 1));
    cpu_dmem_addr  = $urandom;
    cpu_dmem_wstrb = 4'($urandom_range(0, 15));
    cpu_dmem_wdata = $urandom;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", mem_valid); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    checks++; if (cpu_imem_data !== 32'h0) begin errors++; $display("FAIL reset_imem: got %h expected 0", cpu_imem_data); end
    checks++; if (cpu_dmem_rdata !== 32'h0) begin errors++; $display("FAIL reset_dmem: got %h expected 0", cpu_dmem_rdata); end
    resetn = 1'b1;
  endtask

  task automatic test_fetch();
    mem[32'h100 >> 2] = 32'h00500093;
    mem_ready = 1'b1;
    cpu_imem_addr = 32'h100; cpu_dmem_valid = 1'b0;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL fetch_stall0: got %b expected 0", cpu_stall); end
    tick();
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall1: got %b expected 1", cpu_stall); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr: got %h expected 100", mem_addr); end
    checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL fetch_wstrb: got %h expected 0", mem_wstrb); end
    garbage();
    tick();
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL fetch_stall2: got %b expected 0", cpu_stall); end
    checks++; if (cpu_imem_data !== 32'h00500093) begin errors++; $display("FAIL fetch_data: got %h expected 00500093", cpu_imem_data); end
  endtask

  task automatic test_load();
    mem[32'h200 >> 2] = 32'hDEADBEEF;
    mem[32'h104 >> 2] = 32'h00100113;
    cpu_imem_addr = 32'h104; cpu_dmem_valid = 1'b1; cpu_dmem_addr = 32'h200;
    cpu_dmem_wstrb = 4'h0; cpu_dmem_wdata = 32'h0;
    tick();
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL load_stall1: got %b expected 1", cpu_stall); end
    checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL load_daddr: got %h expected 200", mem_addr); end
    garbage();
    tick();
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL load_stall2: got %b expected 1", cpu_stall); end
    checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL load_iaddr: got %h expected 104", mem_addr); end
    tick();
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL load_stall3: got %b expected 0", cpu_stall); end
    checks++; if (cpu_dmem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h expected deadbeef", cpu_dmem_rdata); end
    checks++; if (cpu_imem_data !== 32'h00100113) begin errors++; $display("FAIL load_idata: got %h expected 00100113", cpu_imem_data); end
  endtask

  task automatic test_store();
    mem[32'h300 >> 2] = 32'h11223344;
    mem[32'h108 >> 2] = 32'h00208193;
    cpu_imem_addr = 32'h108; cpu_dmem_valid = 1'b1; cpu_dmem_addr = 32'h300;
    cpu_dmem_wstrb = 4'b0100; cpu_dmem_wdata = 32'h00AB0000;
    tick();
    checks++; if (mem_wstrb !== 4'b0100) begin errors++; $display("FAIL store_wstrb: got %b expected 0100", mem_wstrb); end
    checks++; if (mem_wdata !== 32'h00AB0000) begin errors++; $display("FAIL store_wdata: got %h expected 00ab0000", mem_wdata); end
    checks++; if (mem_addr !== 32'h300) begin errors++; $display("FAIL store_addr: got %h expected 300", mem_addr); end
    garbage();
    tick();
    checks++; if (mem_wstrb !== 4'b0000) begin errors++; $display("FAIL store_iacc_wstrb: got %b expected 0000", mem_wstrb); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL store_iacc_wdata: got %h expected 0", mem_wdata); end
    tick();
    checks++; if (cpu_dmem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_rdata_kept: got %h expected deadbeef", cpu_dmem_rdata); end
    checks++; if (mem[32'h300 >> 2] !== 32'h11AB3344) begin errors++; $display("FAIL store_mem: got %h expected 11ab3344", mem[32'h300 >> 2]); end
  endtask

  task automatic test_wait_states();
    int stalls;
    stalls = 0;
    mem[32'h10C >> 2] = 32'h0030A023;
    cpu_imem_addr = 32'h10C; cpu_dmem_valid = 1'b1; cpu_dmem_addr = 32'h204;
    cpu_dmem_wstrb = 4'hF; cpu_dmem_wdata = 32'h5A5A5A5A;
    mem_ready = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      if (cpu_stall) stalls++;
      checks++;
      if (mem_addr !== 32'h204 || mem_wstrb !== 4'hF || mem_wdata !== 32'h5A5A5A5A)
        begin errors++; $display("FAIL wait_stable cyc%0d: got %h/%h/%h expected 204/f/5a5a5a5a", c, mem_addr, mem_wstrb, mem_wdata); end
      garbage();
      if (c == 3) mem_ready = 1'b1;
      tick();
    end
    if (cpu_stall) stalls++;
    checks++; if (mem_addr !== 32'h10C) begin errors++; $display("FAIL wait_iaddr: got %h expected 10c", mem_addr); end
    tick();
    checks++; if (stalls != 5 || cpu_stall !== 1'b0) begin errors++; $display("FAIL wait_stall_count: got %0d/%b expected 5/0", stalls, cpu_stall); end
    checks++; if (cpu_imem_data !== 32'h0030A023) begin errors++; $display("FAIL wait_idata: got %h expected 0030a023", cpu_imem_data); end
  endtask

  task automatic test_reset_mid();
    mem[32'h114 >> 2] = 32'h00000013;
    cpu_imem_addr = 32'h110; cpu_dmem_valid = 1'b0;
    mem_ready = 1'b0;
    tick();
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", mem_valid); end
    resetn = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL rstmid_drop: got valid=%b stall=%b expected 0/0", mem_valid, cpu_stall); end
    checks++; if (cpu_imem_data !== 32'h0) begin errors++; $display("FAIL rstmid_imem: got %h expected 0", cpu_imem_data); end
    @(negedge clock);
    resetn = 1'b1;
    mem_ready = 1'b1;
    cpu_imem_addr = 32'h114;
    tick();
    checks++; if (mem_addr !== 32'h114 || mem_wstrb !== 4'h0) begin errors++; $display("FAIL rstmid_reissue: got %h/%h expected 114/0", mem_addr, mem_wstrb); end
    tick();
    checks++; if (cpu_imem_data !== 32'h00000013) begin errors++; $display("FAIL rstmid_idata: got %h expected 00000013", cpu_imem_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ia, da, dd, exp_imem, exp_dmem;
    logic [3:0]  dw;
    logic [31:0] e_addr [2];
    logic [3:0]  e_strb [2];
    logic [31:0] e_data [2];
    int kind, n_exp, n_seen;
    bit done;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    exp_dmem = cpu_dmem_rdata === 32'h0 ? 32'h0 : 32'h0;
    exp_dmem = 32'h0;
    for (int n = 0; n < 50; n++) begin
      ia = 32'($urandom_range(0, 255)) << 2;
      da = 32'($urandom_range(0, 255)) << 2;
      dd = $urandom;
      kind = $urandom_range(0, 2);
      dw = (kind == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
      n_exp = 0;
      if (kind != 0) begin
        e_addr[0] = da; e_strb[0] = dw; e_data[0] = (kind == 2) ? dd : 32'h0;
        if (kind == 1) begin
          e_data[0] = dd;
          exp_dmem = ref_mem[da[9:2]];
        end else begin
          ref_mem[da[9:2]] = merge(ref_mem[da[9:2]], dw, dd);
        end
        n_exp = 1;
      end
      e_addr[n_exp] = ia; e_strb[n_exp] = 4'h0; e_data[n_exp] = 32'h0;
      n_exp++;
      exp_imem = ref_mem[ia[9:2]];
      cpu_imem_addr = ia; cpu_dmem_valid = (kind != 0); cpu_dmem_addr = da;
      cpu_dmem_wstrb = dw; cpu_dmem_wdata = dd;
      mem_ready = 1'($urandom_range(0, 1));
      tick();
      n_seen = 0;
      done = 0;
      for (int c = 0; c < 64 && !done; c++) begin
        if (!cpu_stall) done = 1;
        else begin
          mem_ready = 1'($urandom_range(0, 1));
          garbage();
          if (mem_valid && mem_ready) begin
            checks++;
            if (n_seen >= n_exp) begin
              errors++; $display("FAIL b2b_extra_req iss%0d: got addr %h expected none", n, mem_addr);
            end else if (mem_addr !== e_addr[n_seen] || mem_wstrb !== e_strb[n_seen] ||
                         mem_wdata !== e_data[n_seen]) begin
              errors++;
              $display("FAIL b2b_req iss%0d#%0d: got %h/%h/%h expected %h/%h/%h", n, n_seen,
                       mem_addr, mem_wstrb, mem_wdata, e_addr[n_seen], e_strb[n_seen], e_data[n_seen]);
            end
            n_seen++;
          end
          tick();
        end
      end
      checks++; if (!done) begin errors++; $display("FAIL b2b_timeout iss%0d: got stall=%b expected 0", n, cpu_stall); end
      checks++; if (n_seen != n_exp) begin errors++; $display("FAIL b2b_count iss%0d: got %0d expected %0d", n, n_seen, n_exp); end
      checks++; if (cpu_imem_data !== exp_imem) begin errors++; $display("FAIL b2b_idata iss%0d: got %h expected %h", n, cpu_imem_data, exp_imem); end
      checks++; if (cpu_dmem_rdata !== exp_dmem) begin errors++; $display("FAIL b2b_rdata iss%0d: got %h expected %h", n, cpu_dmem_rdata, exp_dmem); end
    end
  endtask

  initial begin
    resetn = 1'b0;
    mem_ready = 1'b1;
    cpu_imem_addr = 32'h0; cpu_dmem_valid = 1'b0; cpu_dmem_addr = 32'h0;
    cpu_dmem_wstrb = 4'h0; cpu_dmem_wdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_wait_states();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
